// File: rtl/fp_mac_seq.sv
// fp_mac_seq: sequential non-fused floating-point MUL/ADD/MAC/LDM unit
// with persistent accumulator, exception flags and start83/done83 handshake.

module fp_mac_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 reset83,
  input  logic                 start83,
  input  logic [1:0]           mode83,
  input  logic [EXP_W+MAN_W:0] a83,
  input  logic [EXP_W+MAN_W:0] b83,
  output logic [EXP_W+MAN_W:0] ans83,
  output logic                 done83,
  output logic                 busy83,
  output logic                 ovf83,
  output logic                 unf83,
  output logic                 nan83
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int MW1 = MAN_W + 1;
  localparam int AW  = MAN_W + 4;
  localparam int SW  = AW + 1;
  localparam int PW  = $clog2(SW);
  localparam int PRW = 2 * MW1;

  localparam logic [EW2-1:0] BIAS_E = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW2-1:0] EMAX_E = EW2'((1 << EXP_W) - 1);
  localparam logic [EW2-1:0] SHMX_E = EW2'(MAN_W + 3);
  localparam logic [EW2-1:0] NPOS_E = EW2'(AW - 1);
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [1:0] MD_ADD = 2'b01;
  localparam logic [1:0] MD_MAC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MUL, S_ALIGN, S_ADD, S_NORM, S_DONE
  } state_t;

  typedef struct packed {
    logic             spc;
    logic             spc_nan;
    logic [W-1:0]     spc_res;
    logic             ps;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MW1-1:0]   ma;
    logic [MW1-1:0]   mb;
    logic             pz;
    logic             qs;
    logic [EXP_W-1:0] qe;
    logic [MW1-1:0]   qm;
    logic             qz;
  } unp_t;

  typedef struct packed {
    logic [EW2-1:0] pe;
    logic [MW1-1:0] pm;
  } mul_t;

  typedef struct packed {
    logic [AW-1:0]  xm;
    logic [AW-1:0]  ym;
    logic           xs;
    logic           ys;
    logic [EW2-1:0] xe;
  } aln_t;

  typedef struct packed {
    logic [SW-1:0] sm;
    logic          ss;
  } add_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] acc_q, acc_d, ans_q, ans_d;
  logic [1:0]   mode_q, mode_d;
  logic         done_q, done_d, busy_q, busy_d;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic         nan_q, nan_d;
  unp_t         unp_q, unp_d;
  mul_t         mul_q, mul_d;
  aln_t         aln_q, aln_d;
  add_t         add_q, add_d;

  logic [W-1:0]     q_w;
  logic [EXP_W-1:0] a_e, b_e, q_e;
  logic [MAN_W-1:0] a_f, b_f, q_f;
  logic a_z, a_i, a_n, b_z, b_i, b_n, q_z, q_i;
  logic is_mul, p_inf, p_zero, p_s, any_nan;

  assign is_mul = (mode_q != MD_ADD);
  assign q_w = (mode_q == MD_ADD) ? b_q :
               (mode_q == MD_MAC) ? acc_q : '0;

  assign a_e = a_q[W-2 -: EXP_W];
  assign b_e = b_q[W-2 -: EXP_W];
  assign q_e = q_w[W-2 -: EXP_W];
  assign a_f = a_q[MAN_W-1:0];
  assign b_f = b_q[MAN_W-1:0];
  assign q_f = q_w[MAN_W-1:0];

  assign a_z = (a_e == '0);
  assign b_z = (b_e == '0);
  assign q_z = (q_e == '0);
  assign a_i = (a_e == EONES) && (a_f == '0);
  assign b_i = (b_e == EONES) && (b_f == '0);
  assign q_i = (q_e == EONES) && (q_f == '0);
  assign a_n = (a_e == EONES) && (a_f != '0);
  assign b_n = (b_e == EONES) && (b_f != '0);

  assign p_inf  = is_mul ? (a_i | b_i) : a_i;
  assign p_zero = is_mul ? (a_z | b_z) : a_z;
  assign p_s    = is_mul ? (a_q[W-1] ^ b_q[W-1]) : a_q[W-1];
  assign any_nan = a_n | b_n
                 | (is_mul & ((a_i & b_z) | (b_i & a_z)))
                 | (p_inf & q_i & (p_s != q_w[W-1]));

  always_comb begin
    unp_d = unp_q;
    if (state_q == S_UNPACK) begin
      unp_d.spc     = any_nan | p_inf | q_i;
      unp_d.spc_nan = any_nan;
      unp_d.spc_res = any_nan ? QNAN :
        {(p_inf ? p_s : q_w[W-1]), EONES, {MAN_W{1'b0}}};
      unp_d.ps = p_s;
      unp_d.ea = a_e;
      unp_d.eb = b_e;
      unp_d.ma = a_z ? '0 : {1'b1, a_f};
      unp_d.mb = b_z ? '0 : {1'b1, b_f};
      unp_d.pz = p_zero;
      unp_d.qs = q_w[W-1];
      unp_d.qe = q_e;
      unp_d.qm = q_z ? '0 : {1'b1, q_f};
      unp_d.qz = q_z;
    end
  end

  logic [PRW-1:0] prod;
  logic [EW2-1:0] e_sum;

  assign prod  = PRW'(unp_q.ma) * PRW'(unp_q.mb);
  assign e_sum = EW2'(unp_q.ea) + EW2'(unp_q.eb) - BIAS_E;

  always_comb begin
    mul_d = mul_q;
    if (state_q == S_MUL) begin
      if (!is_mul) begin
        mul_d.pm = unp_q.ma;
        mul_d.pe = EW2'(unp_q.ea);
      end else if (prod[PRW-1]) begin
        mul_d.pm = prod[PRW-1 -: MW1];
        mul_d.pe = e_sum + EW2'(1);
      end else begin
        mul_d.pm = prod[PRW-2 -: MW1];
        mul_d.pe = e_sum;
      end
    end
  end

  logic [EW2-1:0] q_ex, e_dif, e_mag, sh;
  logic           p_ge;
  logic [AW-1:0]  p_al, q_al;

  assign q_ex  = EW2'(unp_q.qe);
  assign e_dif = mul_q.pe - q_ex;
  assign p_ge  = $signed(mul_q.pe) >= $signed(q_ex);
  assign e_mag = p_ge ? e_dif : -e_dif;
  assign sh    = (e_mag > SHMX_E) ? SHMX_E : e_mag;
  assign p_al  = {mul_q.pm, 3'b000};
  assign q_al  = {unp_q.qm, 3'b000};

  // A zero operand never sets the exponent; the other side passes unshifted.
  always_comb begin
    aln_d = aln_q;
    if (state_q == S_ALIGN) begin
      aln_d.xm = p_al;
      aln_d.xs = unp_q.ps;
      aln_d.xe = mul_q.pe;
      aln_d.ym = '0;
      aln_d.ys = unp_q.ps;
      if (!unp_q.qz) begin
        if (unp_q.pz || !p_ge) begin
          aln_d.xm = q_al;
          aln_d.xs = unp_q.qs;
          aln_d.xe = q_ex;
          aln_d.ys = unp_q.qs;
          if (!unp_q.pz) begin
            aln_d.ym = p_al >> sh;
            aln_d.ys = unp_q.ps;
          end
        end else begin
          aln_d.ym = q_al >> sh;
          aln_d.ys = unp_q.qs;
        end
      end
    end
  end

  always_comb begin
    add_d = add_q;
    if (state_q == S_ADD) begin
      if (aln_q.xs == aln_q.ys) begin
        add_d.sm = {1'b0, aln_q.xm} + {1'b0, aln_q.ym};
        add_d.ss = aln_q.xs;
      end else if (aln_q.xm >= aln_q.ym) begin
        add_d.sm = {1'b0, aln_q.xm - aln_q.ym};
        add_d.ss = aln_q.xs;
      end else begin
        add_d.sm = {1'b0, aln_q.ym - aln_q.xm};
        add_d.ss = aln_q.ys;
      end
    end
  end

  logic [PW-1:0]  pos, sh_l;
  logic [SW-1:0]  nm;
  logic [EW2-1:0] ne;
  logic [W-1:0]   n_res;
  logic           n_ovf, n_unf, n_nan;
  logic           unused_bits;

  always_comb begin
    pos = '0;
    for (int i = 0; i < SW; i++) begin
      if (add_q.sm[i]) pos = PW'(i);
    end
  end

  assign sh_l = PW'(SW - 1) - pos;
  assign nm   = add_q.sm << sh_l;
  assign ne   = aln_q.xe + EW2'(pos) - NPOS_E;

  always_comb begin
    n_res = '0;
    n_ovf = 1'b0;
    n_unf = 1'b0;
    n_nan = 1'b0;
    if (unp_q.spc) begin
      n_res = unp_q.spc_res;
      n_nan = unp_q.spc_nan;
    end else if (add_q.sm != '0) begin
      if (!ne[EW2-1] && ne >= EMAX_E) begin
        n_res = {add_q.ss, EONES, {MAN_W{1'b0}}};
        n_ovf = 1'b1;
      end else if (ne[EW2-1] || ne == '0) begin
        n_res = {add_q.ss, {(W-1){1'b0}}};
        n_unf = 1'b1;
      end else begin
        n_res = {add_q.ss, ne[EXP_W-1:0], nm[SW-2 -: MAN_W]};
      end
    end
  end

  assign unused_bits =
    ^{prod[PRW-MW1-2:0], nm[SW-1], nm[SW-MAN_W-2:0]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    ans_d   = ans_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    nan_d   = nan_q;
    unique case (state_q)
      S_IDLE: begin
        if (start83) begin
          state_d = S_UNPACK;
          a_d     = a83;
          b_d     = b83;
          mode_d  = mode83;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          nan_d   = 1'b0;
        end
      end
      S_UNPACK: state_d = S_MUL;
      S_MUL:    state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM: begin
        state_d = S_DONE;
        ans_d   = n_res;
        ovf_d   = n_ovf;
        unf_d   = n_unf;
        nan_d   = n_nan;
        if (mode_q[1]) acc_d = n_res;
      end
      S_DONE: begin
        if (!done_q) begin
          done_d = 1'b1;
        end else if (!start83) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset83) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      ans_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      nan_q   <= 1'b0;
      unp_q   <= '0;
      mul_q   <= '0;
      aln_q   <= '0;
      add_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      ans_q   <= ans_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      nan_q   <= nan_d;
      unp_q   <= unp_d;
      mul_q   <= mul_d;
      aln_q   <= aln_d;
      add_q   <= add_d;
    end
  end

  assign ans83  = ans_q;
  assign done83 = done_q;
  assign busy83 = busy_q;
  assign ovf83  = ovf_q;
  assign unf83  = unf_q;
  assign nan83  = nan_q;

endmodule

// File: tb/tb_fp_mac_seq.sv
// tb_fp_mac_seq: directed vectors into a scoreboard queue; a monitor
// pops and compares on every rising done83.

module tb_fp_mac_seq;

  localparam logic [1:0] MUL = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] MAC = 2'b10;
  localparam logic [1:0] LDM = 2'b11;

  logic        clk = 1'b0;
  logic        reset83 = 1'b0;
  logic        start83 = 1'b0;
  logic [1:0]  mode83 = 2'b00;
  logic [15:0] a83 = '0;
  logic [15:0] b83 = '0;
  logic [15:0] ans83;
  logic        done83, busy83, ovf83, unf83, nan83;

  fp_mac_seq dut (
    .clk     (clk),
    .reset83 (reset83),
    .start83 (start83),
    .mode83  (mode83),
    .a83     (a83),
    .b83     (b83),
    .ans83   (ans83),
    .done83  (done83),
    .busy83  (busy83),
    .ovf83   (ovf83),
    .unf83   (unf83),
    .nan83   (nan83)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ans;
    logic [2:0]  flg;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   op_id = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done83 && !prev) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_done: ans %h with empty queue", ans83);
        end else begin
          e = sb.pop_front();
          chk($sformatf("op%0d {ans,ovf,unf,nan}", e.id),
              {13'b0, ans83, ovf83, unf83, nan83},
              {13'b0, e.ans, e.flg});
        end
      end
      prev = done83;
    end
  end

  task automatic run(input logic [1:0] m, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] ea,
                     input logic [2:0] ef, input int hold);
    int cyc;
    @(negedge clk);
    mode83  = m;
    a83     = a;
    b83     = b;
    start83 = 1'b1;
    sb.push_back('{ans: ea, flg: ef, id: op_id});
    op_id++;
    cyc = 0;
    while (!done83 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("busy_flags_clear", {busy83, ovf83, unf83, nan83}, 4'b1000);
        a83    = 16'($urandom);
        b83    = 16'($urandom);
        mode83 = 2'($urandom);
      end
    end
    chk("latency_negedges", cyc, 7);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_done_busy", {done83, busy83}, 2'b11);
    end
    start83 = 1'b0;
    @(negedge clk);
    chk("release_done_busy", {done83, busy83}, 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", {ans83, done83, busy83, ovf83, unf83, nan83}, '0);
    reset83 = 1'b1;

    run(MUL, 16'h3400, 16'h3000, 16'h2800, 3'b000, 0);
    run(MUL, 16'h3800, 16'hBA00, 16'hB600, 3'b000, 0);
    run(ADD, 16'h3400, 16'h3000, 16'h3600, 3'b000, 3);
    run(ADD, 16'h3800, 16'hB800, 16'h0000, 3'b000, 0);
    run(LDM, 16'h3800, 16'h3800, 16'h3400, 3'b000, 0);
    run(MAC, 16'h3400, 16'h3000, 16'h3480, 3'b000, 0);
    run(MUL, 16'h3C00, 16'h4000, 16'h4000, 3'b000, 0);
    run(MAC, 16'h3400, 16'h3000, 16'h3500, 3'b000, 0);
    run(MUL, 16'h7BFF, 16'h4000, 16'h7C00, 3'b100, 0);
    run(MUL, 16'h0400, 16'h0400, 16'h0000, 3'b010, 0);
    run(MUL, 16'h7E00, 16'h3C00, 16'h7E00, 3'b001, 0);
    run(MUL, 16'h7C00, 16'h0000, 16'h7E00, 3'b001, 0);
    run(MUL, 16'hFC00, 16'h3C00, 16'hFC00, 3'b000, 0);
    run(ADD, 16'h7C00, 16'hFC00, 16'h7E00, 3'b001, 0);

    // abort a MAC while it sits in ALIGN
    @(negedge clk);
    mode83  = MAC;
    a83     = 16'h3400;
    b83     = 16'h3000;
    start83 = 1'b1;
    repeat (3) @(negedge clk);
    reset83 = 1'b0;
    @(negedge clk);
    reset83 = 1'b1;
    start83 = 1'b0;
    chk("abort_state", {ans83, done83, busy83, ovf83, unf83, nan83}, '0);

    run(MAC, 16'h3400, 16'h3000, 16'h2800, 3'b000, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
